// File: rtl/pong_graph_anim.sv
// Pong graphics and animation: draws wall, paddle and ball, and steps the
// paddle and ball once per frame on the first clock at pixel (0,481).
module pong_graph_anim #(
    parameter int PAD_V     = 4,
    parameter int BALL_V    = 2,
    parameter int BALL_SIZE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] rgb,
    output logic        miss,
    output logic [3:0]  miss_cnt
);
    localparam logic signed [10:0] V_POS    = 11'(BALL_V);
    localparam logic signed [10:0] V_NEG    = -11'(BALL_V);
    localparam logic [10:0]        BALL_EXT = 11'(BALL_SIZE - 1);
    localparam logic [9:0]         PAD_STEP = 10'(PAD_V);
    localparam logic [9:0]         PAD_LIM  = 10'(407 - PAD_V);

    logic                     match_q, match_d;
    logic [11:0]              rgb_q, rgb_d;
    logic                     miss_q, miss_d;
    logic [3:0]               miss_cnt_q, miss_cnt_d;
    logic [9:0]               pad_top_q, pad_top_d;
    logic [9:0]               bx_q, bx_d, by_q, by_d;
    logic signed [10:0]       dx_q, dx_d, dy_q, dy_d;

    logic        refr_tick;
    logic [10:0] ball_r, ball_b, pad_bot;
    logic        wall_on, ball_on, pad_on, pad_hit;
    logic signed [10:0] dx_n, dy_n;

    assign match_d   = (pixel_x == 10'd0) && (pixel_y == 10'd481);
    assign refr_tick = match_d && !match_q;

    // Right/bottom ball edges and paddle bottom kept 11 bits wide so no
    // comparison wraps near the 10-bit limit.
    assign ball_r  = {1'b0, bx_q} + BALL_EXT;
    assign ball_b  = {1'b0, by_q} + BALL_EXT;
    assign pad_bot = {1'b0, pad_top_q} + 11'd72;

    assign wall_on = (pixel_x >= 10'd32) && (pixel_x <= 10'd35);
    assign ball_on = (pixel_x >= bx_q) && ({1'b0, pixel_x} <= ball_r)
                  && (pixel_y >= by_q) && ({1'b0, pixel_y} <= ball_b);
    assign pad_on  = (pixel_x >= 10'd600) && (pixel_x <= 10'd603)
                  && (pixel_y >= pad_top_q) && ({1'b0, pixel_y} <= pad_bot);
    assign pad_hit = (ball_r >= 11'd600) && (ball_r <= 11'd603)
                  && (ball_b >= {1'b0, pad_top_q}) && ({1'b0, by_q} <= pad_bot);

    always_comb begin
        rgb_d = 12'h000;
        if (!video_on)    rgb_d = 12'h000;
        else if (wall_on) rgb_d = 12'h00f;
        else if (ball_on) rgb_d = 12'hf00;
        else if (pad_on)  rgb_d = 12'h0f0;
    end

    always_comb begin
        pad_top_d  = pad_top_q;
        bx_d       = bx_q;
        by_d       = by_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        dx_n       = dx_q;
        dy_n       = dy_q;
        miss_d     = 1'b0;
        miss_cnt_d = miss_cnt_q;
        if (refr_tick) begin
            if (btn_up && !btn_down)
                pad_top_d = (pad_top_q < PAD_STEP) ? 10'd0 : pad_top_q - PAD_STEP;
            else if (btn_down && !btn_up)
                pad_top_d = (pad_top_q > PAD_LIM) ? 10'd407 : pad_top_q + PAD_STEP;

            if (ball_r >= 11'd639) begin
                bx_d       = 10'd580;
                by_d       = 10'd238;
                dx_d       = V_NEG;
                dy_d       = V_POS;
                miss_d     = 1'b1;
                miss_cnt_d = miss_cnt_q + 4'd1;
            end else begin
                if (by_q <= 10'd1)          dy_n = V_POS;
                else if (ball_b >= 11'd478) dy_n = V_NEG;
                if (bx_q <= 10'd36)         dx_n = V_POS;
                else if (pad_hit)           dx_n = V_NEG;
                dx_d = dx_n;
                dy_d = dy_n;
                bx_d = 10'({1'b0, bx_q} + dx_n);
                by_d = 10'({1'b0, by_q} + dy_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_q    <= 1'b0;
            rgb_q      <= 12'h000;
            miss_q     <= 1'b0;
            miss_cnt_q <= 4'd0;
            pad_top_q  <= 10'd204;
            bx_q       <= 10'd580;
            by_q       <= 10'd238;
            dx_q       <= V_NEG;
            dy_q       <= V_POS;
        end else begin
            match_q    <= match_d;
            rgb_q      <= rgb_d;
            miss_q     <= miss_d;
            miss_cnt_q <= miss_cnt_d;
            pad_top_q  <= pad_top_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
        end
    end

    assign rgb      = rgb_q;
    assign miss     = miss_q;
    assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_pong_graph_anim.sv
// Scoreboard bench for pong_graph_anim: a frame-level reference model predicts
// rgb/miss/miss_cnt for every driven clock; a monitor compares them.
module tb_pong_graph_anim;
    localparam int PAD_V  = 4;
    localparam int BALL_V = 2;
    localparam int BS     = 8;

    logic        clk = 1'b0;
    logic        rst, video_on, btn_up, btn_down;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] rgb;
    logic        miss;
    logic [3:0]  miss_cnt;

    pong_graph_anim #(.PAD_V(PAD_V), .BALL_V(BALL_V), .BALL_SIZE(BS)) dut (
        .clk(clk), .rst(rst), .video_on(video_on), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .btn_up(btn_up), .btn_down(btn_down),
        .rgb(rgb), .miss(miss), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        miss;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: ball corner, velocity, paddle top, misses.
    int m_bx, m_by, m_dx, m_dy, m_pad, m_cnt, m_total;
    bit m_prev;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (rgb !== e.rgb || miss !== e.miss || miss_cnt !== e.cnt) begin
                miscompares++;
                $display("FAIL pixel_out cyc %0d: got rgb=%h miss=%b cnt=%0d, want rgb=%h miss=%b cnt=%0d",
                         cyc, rgb, miss, miss_cnt, e.rgb, e.miss, e.cnt);
            end
        end
    end

    function automatic logic [11:0] colour(bit vo, int x, int y);
        if (!vo) return 12'h000;
        if (x >= 32 && x <= 35) return 12'h00f;
        if (x >= m_bx && x <= m_bx + BS - 1 && y >= m_by && y <= m_by + BS - 1) return 12'hf00;
        if (x >= 600 && x <= 603 && y >= m_pad && y <= m_pad + 72) return 12'h0f0;
        return 12'h000;
    endfunction

    task automatic model_reset();
        m_bx = 580; m_by = 238; m_dx = -BALL_V; m_dy = BALL_V;
        m_pad = 204; m_cnt = 0; m_prev = 0;
    endtask

    // One frame of game rules, evaluated on a fresh (0,481) arrival.
    task automatic model_frame(bit up, bit dn, output bit missed);
        int ndx, ndy, npad;
        missed = 0;
        npad = m_pad;
        if (up && !dn)      npad = (m_pad < PAD_V) ? 0 : m_pad - PAD_V;
        else if (dn && !up) npad = (m_pad > 407 - PAD_V) ? 407 : m_pad + PAD_V;
        if (m_bx + BS - 1 >= 639) begin
            m_bx = 580; m_by = 238; m_dx = -BALL_V; m_dy = BALL_V;
            m_cnt = (m_cnt + 1) % 16;
            m_total++;
            missed = 1;
        end else begin
            ndx = m_dx; ndy = m_dy;
            if (m_by <= 1)                ndy = BALL_V;
            else if (m_by + BS - 1 >= 478) ndy = -BALL_V;
            if (m_bx <= 36) ndx = BALL_V;
            else if (m_bx + BS - 1 >= 600 && m_bx + BS - 1 <= 603 &&
                     m_by + BS - 1 >= m_pad && m_by <= m_pad + 72) ndx = -BALL_V;
            m_dx = ndx; m_dy = ndy;
            m_bx = (m_bx + ndx) & 1023;
            m_by = (m_by + ndy) & 1023;
        end
        m_pad = npad;
    endtask

    task automatic step(bit r, bit vo, int x, int y, bit up, bit dn);
        exp_t e;
        bit   hit, missed;
        rst = r; video_on = vo; pixel_x = 10'(x); pixel_y = 10'(y);
        btn_up = up; btn_down = dn;
        e.due  = cyc + 1;
        e.rgb  = r ? 12'h000 : colour(vo, x, y);
        e.miss = 1'b0;
        if (r) model_reset();
        else begin
            hit = (x == 0 && y == 481);
            if (hit && !m_prev) begin
                model_frame(up, dn, missed);
                e.miss = missed;
            end
            m_prev = hit;
        end
        e.cnt = 4'(m_cnt);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic int clip(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Probe biased toward object edges so position errors show up in rgb.
    task automatic rand_probe(bit up, bit dn);
        int x, y;
        bit vo;
        vo = ($urandom_range(0, 9) != 0);
        case ($urandom_range(0, 3))
            0: begin x = m_bx + $urandom_range(0, BS + 1) - 1; y = m_by + $urandom_range(0, BS + 1) - 1; end
            1: begin x = 599 + $urandom_range(0, 5); y = m_pad + $urandom_range(0, 74) - 1; end
            2: begin x = 31 + $urandom_range(0, 5); y = $urandom_range(0, 479); end
            default: begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
        endcase
        step(0, vo, clip(x, 639), clip(y, 479), up, dn);
    endtask

    task automatic frame(bit up, bit dn, int probes);
        step(0, 1, 0, 481, up, dn);
        for (int i = 0; i < probes; i++) rand_probe(up, dn);
    endtask

    int fixed_pts[13][3] = '{
        '{1, 580, 238}, '{1, 587, 245}, '{1, 588, 238}, '{1, 579, 238},
        '{1, 600, 204}, '{1, 603, 276}, '{1, 600, 277}, '{1, 604, 210},
        '{1, 33, 100},  '{0, 33, 100},  '{1, 31, 100},  '{1, 36, 100},
        '{1, 320, 200}
    };

    initial begin
        m_total = 0;
        rst = 1; video_on = 0; btn_up = 0; btn_down = 0; pixel_x = 0; pixel_y = 0;
        model_reset();
        #1;
        for (int i = 0; i < 5; i++)
            step(1, 1, $urandom_range(0, 639), $urandom_range(0, 479), 1, 0);
        foreach (fixed_pts[i])
            step(0, fixed_pts[i][0] != 0, fixed_pts[i][1], fixed_pts[i][2], 0, 0);

        // (0,481) held two clocks must advance the ball exactly once
        step(0, 1, 0, 481, 0, 0);
        step(0, 1, 0, 481, 0, 0);
        step(0, 1, 578, 240, 0, 0);
        step(0, 1, 577, 240, 0, 0);
        step(0, 1, 585, 247, 0, 0);
        step(0, 1, 586, 247, 0, 0);

        for (int f = 0; f < 60; f++) frame(1, 0, 2);
        step(0, 1, 600, 0, 0, 0);
        step(0, 1, 600, 72, 0, 0);
        step(0, 1, 600, 73, 0, 0);
        for (int f = 0; f < 10; f++) frame(1, 1, 2);
        for (int f = 0; f < 200; f++) frame($urandom_range(0, 1), $urandom_range(0, 1), 2);

        // Park the paddle at the top and let the ball run out repeatedly
        for (int f = 0; f < 110; f++) frame(1, 0, 1);
        begin
            int start;
            start = m_total;
            for (int f = 0; f < 15000 && m_total < start + 17; f++) frame(1, 0, 1);
        end

        begin
            int f;
            f = 0;
            while (m_bx != 400 && f < 2000) begin
                frame(0, 0, 1);
                f++;
            end
        end
        step(1, 1, 400, m_by, 0, 1);
        step(0, 1, 580, 238, 0, 0);
        step(0, 1, 600, 204, 0, 0);
        step(0, 1, 587, 245, 0, 0);
        for (int f = 0; f < 20; f++) frame($urandom_range(0, 1), $urandom_range(0, 1), 2);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pong_graph_anim.md
PONG_GRAPH_ANIM -- requirements
Module: pong_graph_anim

Interface
REQ-001 SHALL have parameter PAD_V, default 4, meaning paddle step in pixels per frame.
REQ-002 SHALL have parameter BALL_V, default 2, meaning ball step magnitude per axis per frame.
REQ-003 SHALL have parameter BALL_SIZE, default 8, meaning ball edge length in pixels.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-006 SHALL have port video_on, input, 1, the active-display flag from the sync stage.
REQ-007 SHALL have port pixel_x, input, 10, the current horizontal pixel count from the sync stage.
REQ-008 SHALL have port pixel_y, input, 10, the current vertical pixel count from the sync stage.
REQ-009 SHALL have port btn_up, input, 1, the paddle-up request, level-sensitive and already debounced.
REQ-010 SHALL have port btn_down, input, 1, the paddle-down request, level-sensitive and already debounced.
REQ-011 SHALL have port rgb, output, 12, the registered pixel colour.
REQ-012 SHALL have port miss, output, 1, a one-clock pulse issued when the ball exits past the paddle.
REQ-013 SHALL have port miss_cnt, output, 4, the miss counter, which wraps from 15 to 0.

Function
REQ-014 SHALL assert internal refr_tick for exactly one clk on the first clock where (pixel_x,pixel_y)==(0,481), using a registered previous-match flag, even when that coordinate is held for several clocks.
REQ-015 SHALL define wall as x 32..35 over all y; paddle as x 600..603, y pad_top..pad_top+72; ball as x bx..bx+BALL_SIZE-1, y by..by+BALL_SIZE-1.
REQ-016 SHALL register rgb with 1-clock latency from pixel_x/pixel_y/video_on, using priority: !video_on 12'h000; wall 12'h00f; ball 12'hf00; paddle 12'h0f0; otherwise 12'h000.
REQ-017 SHALL change pad_top only on refr_tick: btn_up alone gives pad_top = (pad_top<PAD_V) ? 0 : pad_top-PAD_V; btn_down alone gives pad_top = (pad_top>407-PAD_V) ? 407 : pad_top+PAD_V; both or neither leave it unchanged.
REQ-018 SHALL hold bx/by as 10-bit unsigned and dx/dy as signed ±BALL_V, and SHALL change them only on refr_tick.
REQ-019 SHALL compute new velocity on refr_tick from the current position, then apply position += new velocity in that same tick.
REQ-020 SHALL apply these velocity rules: by<=1 sets dy=+BALL_V; by+BALL_SIZE-1>=478 sets dy=-BALL_V; bx<=36 sets dx=+BALL_V.
REQ-021 SHALL set dx=-BALL_V on paddle hit, defined as bx+BALL_SIZE-1 in 600..603 AND by+BALL_SIZE-1>=pad_top AND by<=pad_top+72.
REQ-022 SHALL treat bx+BALL_SIZE-1>=639 on refr_tick as a miss, taking precedence over all other ball rules: bx=580, by=238, dx=-BALL_V, dy=+BALL_V, miss=1 for one clk, and miss_cnt+1 modulo 16.
REQ-023 SHALL apply simultaneous y-bounce and x-bounce rules in the same tick, and SHALL give the paddle update and the ball update the same tick, with the ball hit test using pre-update pad_top.
REQ-024 SHALL NOT drive miss high except on a miss refr_tick.

Reset
REQ-025 SHALL, while rst=1 on a clk edge, set rgb=12'h000, miss=0, miss_cnt=0, pad_top=204, bx=580, by=238, dx=-BALL_V, dy=+BALL_V, and clear the refr_tick edge flag.
REQ-026 SHALL let rst override refr_tick and buttons in the same cycle; after reset is asserted mid-frame, animation resumes at the next refr_tick following release.

Verification
REQ-027 SHALL cover: rst=1 for 5 clk, then released -> rgb=000, miss_cnt=0, first frame draws ball f00 at (580..587,238..245) and paddle 0f0 at (600..603,204..276).
REQ-028 SHALL cover: video_on=1, pixel (33,100) -> rgb=00f one clk later; video_on=0 at the same pixel -> rgb=000 one clk later.
REQ-029 SHALL cover: (0,481) held for 2 clk after reset -> exactly one refr_tick, bx=578, by=240.
REQ-030 SHALL cover: btn_up held for 60 frames -> pad_top reaches 0 and stays there; btn_up+btn_down held -> pad_top unchanged.
REQ-031 SHALL cover: ball forced to approach with pad_top moved away -> miss pulses for 1 clk, bx=580, by=238, miss_cnt=1; after 16 misses miss_cnt=0.
REQ-032 SHALL cover: rst asserted mid-frame with bx=400 -> next clk bx=580, pad_top=204, rgb=000.
